ps2_rx_fifo: RTL and testbench

Parametrised PS/2 receive front end that replaces the fixed 8-entry keyboard receiver. It synchronises and deglitches the raw PS/2 lines and deserialises 11-bit frames. Good bytes, optionally merged with E0/F0 prefixes, are buffered in a configurable FIFO behind a valid/ready interface. It sits between the board PS/2 pins and the keyboard scan-code FSM.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_line_filter.sv | 59 +++++
 rtl/ps2_rx_fifo.sv | 199 +++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path.
//   ps2_state_t : frame FSM states (IDLE, SHIFT, CHECK)
//   PS2_EXT     : extended-key prefix byte
//   PS2_BRK     : break (key release) prefix byte
//   FRAME_BITS  : bits per PS/2 frame (start, 8 data, parity, stop)
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } ps2_state_t;

  localparam logic [7:0]  PS2_EXT    = 8'hE0;
  localparam logic [7:0]  PS2_BRK    = 8'hF0;
  localparam int unsigned FRAME_BITS = 11;

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-FF synchronisers on both pins, a debounce
// filter on the clock line and a strobe on each filtered falling edge.
//   clk      in  : system clock
//   rst      in  : synchronous active-high reset
//   ps2_clk  in  : raw PS/2 clock pin
//   ps2_data in  : raw PS/2 data pin
//   data_s   out : synchronised data line
//   sampling out : one-cycle strobe, filtered clock has just fallen
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic sampling
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          flip;

  // cnt holds how many consecutive samples have already disagreed with
  // filt; the FILTER_LEN-th disagreeing sample toggles the output.
  assign differ = (clk_sync[1] != filt);
  assign flip   = differ && (cnt == CW'(FILTER_LEN - 1));
  assign data_s = dat_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      filt     <= 1'b1;
      cnt      <= '0;
      sampling <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      sampling <= flip & filt;
      if (differ) begin
        if (flip) begin
          filt <= ~filt;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receive front end: frame deserialiser, optional E0/F0 prefix
// folding and a buffered valid/ready output FIFO.
//   clk, rst          : system clock, synchronous active-high reset
//   ps2_clk, ps2_data : raw PS/2 pins
//   out_data/ext/brk  : head entry (scan code, E0 seen, F0 seen)
//   out_valid         : FIFO non-empty
//   out_ready         : consumer pops head on out_valid && out_ready
//   level             : current entry count
//   overflow, parity_err, frame_err, timeout_err : sticky error flags
//   clr_err           : clears the sticky flags
//   sampling          : strobe on each filtered ps2_clk falling edge
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned DECODE      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  output logic [7:0]                 out_data,
  output logic                       out_ext,
  output logic                       out_brk,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       timeout_err,
  input  logic                       clr_err,
  output logic                       sampling
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic             data_s;
  ps2_state_t       state;
  logic [3:0]       bit_cnt;
  logic [10:0]      shreg;
  logic [TW-1:0]    tcnt;
  logic             ext_pend;
  logic             brk_pend;

  logic             in_check;
  logic             start_bad;
  logic             stop_bad;
  logic             par_bad;
  logic             frame_ok;
  logic             bad_evt;
  logic             timeout_evt;
  logic [7:0]       rx_byte;
  logic             is_prefix;
  logic             push;

  logic [9:0]       mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             full;
  logic             pop;
  logic             wr_en;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .data_s  (data_s),
    .sampling(sampling)
  );

  // Bits shift in from the top, so after eleven captures shreg[0] is the
  // start bit and shreg[10] the stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tcnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sampling) begin
            shreg   <= {data_s, shreg[10:1]};
            bit_cnt <= 4'd1;
            tcnt    <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (sampling) begin
            shreg <= {data_s, shreg[10:1]};
            tcnt  <= '0;
            if (bit_cnt == 4'(FRAME_BITS - 1)) begin
              state <= CHECK;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (timeout_evt) begin
            tcnt  <= '0;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        CHECK:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_check    = (state == CHECK);
    start_bad   = shreg[0];
    stop_bad    = ~shreg[10];
    par_bad     = ~(^shreg[9:1]);
    rx_byte     = shreg[8:1];
    frame_ok    = in_check & ~start_bad & ~stop_bad & ~par_bad;
    bad_evt     = in_check & (start_bad | stop_bad | par_bad);
    timeout_evt = (state == SHIFT) && !sampling && (tcnt == TW'(TIMEOUT_CYC));
    is_prefix   = (DECODE != 0) && ((rx_byte == PS2_EXT) || (rx_byte == PS2_BRK));
    push        = frame_ok & ~is_prefix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (bad_evt || timeout_evt) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (frame_ok) begin
      if (is_prefix) begin
        if (rx_byte == PS2_EXT) ext_pend <= 1'b1;
        else                    brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  assign full      = (count == LW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign wr_en     = push & (~full | pop);
  assign level     = count;
  assign {out_ext, out_brk, out_data} = mem[rd_ptr];

  // Clear first, then set: an event in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (clr_err) begin
        overflow    <= 1'b0;
        parity_err  <= 1'b0;
        frame_err   <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (in_check && par_bad)                 parity_err  <= 1'b1;
      if (in_check && (start_bad || stop_bad)) frame_err   <= 1'b1;
      if (timeout_evt)                         timeout_err <= 1'b1;
      if (push && full && !pop)                overflow    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ext_pend, brk_pend, rx_byte};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

  localparam int DEPTH   = 8;
  localparam int FLEN    = 4;
  localparam int TMO     = 200;
  localparam int HALF    = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic out_ready = 1'b0;
  logic clr_err = 1'b0;

  logic [7:0] d0, d1;
  logic       e0, e1, b0, b1, v0, v1;
  logic [3:0] l0, l1;
  logic       ov0, ov1, pe0, pe1, fe0, fe1, te0, te1, s0, s1;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYC(TMO), .DECODE(0)) u0 (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out_data(d0), .out_ext(e0), .out_brk(b0), .out_valid(v0), .out_ready(out_ready),
    .level(l0), .overflow(ov0), .parity_err(pe0), .frame_err(fe0), .timeout_err(te0),
    .clr_err(clr_err), .sampling(s0));

  ps2_rx_fifo #(.DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYC(TMO), .DECODE(1)) u1 (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out_data(d1), .out_ext(e1), .out_brk(b1), .out_valid(v1), .out_ready(out_ready),
    .level(l1), .overflow(ov1), .parity_err(pe1), .frame_err(fe1), .timeout_err(te1),
    .clr_err(clr_err), .sampling(s1));

  int checks = 0;
  int errors = 0;

  // Reference model: one queue of {ext,brk,byte} per instance plus flags.
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  bit m_ov[2], m_pe[2], m_fe[2], m_te[2];
  bit m_ext, m_brk;
  bit busy = 1'b1;
  int edges = 0;
  int sc0 = 0, sc1 = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (s0) sc0++;
    if (s1) sc1++;
  end

  // Cycle-by-cycle comparison whenever no frame is in flight.
  always @(negedge clk) begin
    if (!busy && !rst) begin
      chk("u0_level", l0, q0.size());
      chk("u0_valid", v0, q0.size() != 0);
      if (q0.size() != 0) chk("u0_head", {e0, b0, d0}, q0[0]);
      chk("u0_flags", {ov0, pe0, fe0, te0}, {m_ov[0], m_pe[0], m_fe[0], m_te[0]});
      chk("u1_level", l1, q1.size());
      chk("u1_valid", v1, q1.size() != 0);
      if (q1.size() != 0) chk("u1_head", {e1, b1, d1}, q1[0]);
      chk("u1_flags", {ov1, pe1, fe1, te1}, {m_ov[1], m_pe[1], m_fe[1], m_te[1]});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic ps2_bit(input bit b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    edges++;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      m_ov[i] = 0; m_pe[i] = 0; m_fe[i] = 0; m_te[i] = 0;
    end
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic model_frame(input logic [7:0] d, input bit par, input bit start, input bit stop);
    bit par_ok, fr_ok;
    par_ok = (($countones(d) + par) % 2) == 1;
    fr_ok  = (start == 0) && (stop == 1);
    for (int i = 0; i < 2; i++) begin
      if (!par_ok) m_pe[i] = 1;
      if (!fr_ok)  m_fe[i] = 1;
    end
    if (!par_ok || !fr_ok) begin
      m_ext = 0;
      m_brk = 0;
      return;
    end
    if (q0.size() == DEPTH) m_ov[0] = 1;
    else q0.push_back({2'b00, d});
    if (d == 8'hE0) m_ext = 1;
    else if (d == 8'hF0) m_brk = 1;
    else begin
      if (q1.size() == DEPTH) m_ov[1] = 1;
      else q1.push_back({m_ext, m_brk, d});
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit flip_par, input bit bad_start, input bit bad_stop);
    bit par, st, sp;
    par = ~(^d) ^ flip_par;
    st  = bad_start;
    sp  = ~bad_stop;
    busy = 1'b1;
    ps2_bit(st);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(sp);
    ps2_data = 1'b1;
    wait_cyc(30);
    model_frame(d, par, st, sp);
    busy = 1'b0;
  endtask

  task automatic send_good(input logic [7:0] d);
    send(d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_cycle(input bit r);
    @(negedge clk);
    out_ready = r;
    @(posedge clk);
    if (r) begin
      if (q0.size() != 0) void'(q0.pop_front());
      if (q1.size() != 0) void'(q1.pop_front());
    end
    #1 out_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && (q0.size() != 0 || q1.size() != 0); i++) pop_cycle(1'b1);
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m_ov[i] = 0; m_pe[i] = 0; m_fe[i] = 0; m_te[i] = 0;
    end
    #1 clr_err = 1'b0;
  endtask

  task automatic do_reset();
    busy = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    #1 rst = 1'b0;
    model_reset();
    wait_cyc(2);
    busy = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int sc_before;
    model_reset();
    wait_cyc(4);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", v0, 0);
    chk("rst_level", l0, 0);
    chk("rst_flags", {ov0, pe0, fe0, te0, s0}, 0);
    busy = 1'b0;

    // Raw byte, then pop.
    send_good(8'h1C);
    @(negedge clk);
    chk("lit_1c_data", d0, 8'h1C);
    chk("lit_1c_extbrk", {e0, b0}, 0);
    chk("lit_1c_level", l0, 1);
    pop_cycle(1'b1);
    @(negedge clk);
    chk("lit_pop_level", l0, 0);
    chk("lit_pop_valid", v0, 0);

    // Prefix folding.
    send_good(8'hF0);
    send_good(8'h1C);
    @(negedge clk);
    chk("lit_f0_level", l1, 1);
    chk("lit_f0_head", {e1, b1, d1}, {2'b01, 8'h1C});
    chk("lit_raw_f0_level", l0, 2);
    drain();
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    @(negedge clk);
    chk("lit_e0f0_head", {e1, b1, d1}, {2'b11, 8'h75});
    chk("lit_e0f0_level", l1, 1);
    drain();

    // Parity and framing errors.
    send(8'h1C, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_par_err", pe0, 1);
    chk("lit_par_level", l0, 0);
    clear_flags();
    @(negedge clk);
    chk("lit_par_clr", pe0, 0);
    send(8'h1C, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("lit_frame_err", fe0, 1);
    clear_flags();

    // Overflow and ordering.
    for (int i = 1; i <= 9; i++) send_good(8'(i));
    @(negedge clk);
    chk("lit_ovf_level", l0, 8);
    chk("lit_ovf_flag", ov0, 1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("lit_ovf_order", d0, i);
      pop_cycle(1'b1);
    end
    clear_flags();

    // Timeout on a partial frame, then a clean frame.
    busy = 1'b1;
    for (int i = 0; i < 5; i++) ps2_bit(1'b0);
    wait_cyc(TMO + 100);
    for (int i = 0; i < 2; i++) m_te[i] = 1;
    m_ext = 0;
    m_brk = 0;
    busy = 1'b0;
    @(negedge clk);
    chk("lit_timeout", te0, 1);
    send_good(8'h2A);
    @(negedge clk);
    chk("lit_after_tmo", d0, 8'h2A);
    drain();
    clear_flags();

    // Short glitch must not produce a sampling strobe.
    busy = 1'b1;
    sc_before = sc0;
    @(negedge clk);
    ps2_clk = 1'b0;
    wait_cyc(2);
    #1 ps2_clk = 1'b1;
    wait_cyc(20);
    busy = 1'b0;
    chk("glitch_sampling", sc0 - sc_before, 0);
    send_good(8'h1C);
    @(negedge clk);
    chk("lit_after_glitch", d0, 8'h1C);

    // Reset in the middle of a frame.
    send_good(8'h33);
    busy = 1'b1;
    for (int i = 0; i < 6; i++) ps2_bit(i[0]);
    do_reset();
    @(negedge clk);
    chk("lit_rst_level", l0, 0);
    chk("lit_rst_flags", {ov0, pe0, fe0, te0}, 0);
    send_good(8'h1C);
    @(negedge clk);
    chk("lit_rst_next", {v0, d0}, {1'b1, 8'h1C});
    drain();

    // Randomised traffic.
    for (int n = 0; n < 50; n++) begin
      logic [7:0] d;
      int kind, err;
      kind = $urandom_range(0, 9);
      d = (kind == 0) ? 8'hE0 : (kind == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      err = $urandom_range(0, 15);
      send(d, err == 0 || err == 3, err == 2, err == 1 || err == 3);
      for (int k = $urandom_range(0, 3); k > 0; k--) pop_cycle($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) clear_flags();
    end
    drain();

    wait_cyc(5);
    chk("sampling_count_u0", sc0, edges);
    chk("sampling_count_u1", sc1, edges);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
